npc_pc_sequencer: RTL

Parametrised PC/control sequencer for the multi-cycle NPC. It owns the architectural PC and drives the fetch → execute → commit handshake loop. It resolves redirects (sequential next_pc, ecall→mtvec, mret→mepc, misaligned-target trap) and issues the trap CSR writes. It also latches ebreak halt state and exit code, counts retired instructions, and detects fetch timeout.

---
 rtl/npc_pkg.sv | 22 ++
 rtl/npc_redirect_mux.sv | 47 ++++
 rtl/npc_pc_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC control path: sequencer states, exit codes,
// trap causes and the system-instruction encodings also used by the IDU.
package npc_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    WAIT_INST = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [31:0] EXIT_FETCH_TIMEOUT = 32'hDEAD_0001;

  localparam int unsigned ECALL_M         = 11;
  localparam int unsigned INST_MISALIGNED = 0;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

endpackage

// File: rtl/npc_redirect_mux.sv
// Priority select of the post-commit PC, trap write data and halt decision
// for the instruction completing in WAIT_DONE.
module npc_redirect_mux
  import npc_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int unsigned ECALL_CAUSE    = ECALL_M,
  parameter int unsigned MISALIGN_CAUSE = INST_MISALIGNED
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] exu_next_pc,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic            is_ebreak,
  output logic [XLEN-1:0] next_pc,
  output logic            trap,
  output logic [XLEN-1:0] trap_mepc,
  output logic [XLEN-1:0] trap_mcause,
  output logic            halt
);

  // mtvec and mepc are taken as-is; only the EXU target is alignment-checked.
  always_comb begin
    next_pc     = exu_next_pc;
    trap        = 1'b0;
    trap_mepc   = pc;
    trap_mcause = '0;
    halt        = 1'b0;
    if (is_ebreak) begin
      next_pc = pc;
      halt    = 1'b1;
    end else if (is_ecall) begin
      next_pc     = mtvec;
      trap        = 1'b1;
      trap_mcause = XLEN'(ECALL_CAUSE);
    end else if (is_mret) begin
      next_pc = mepc;
    end else if (exu_next_pc[1:0] != 2'b00) begin
      next_pc     = mtvec;
      trap        = 1'b1;
      trap_mcause = XLEN'(MISALIGN_CAUSE);
    end
  end

endmodule

// File: rtl/npc_pc_sequencer.sv
// PC owner and fetch/issue/commit sequencer for the multi-cycle NPC.
//
// state     | meaning
// ----------+---------------------------------------------------------
// FETCH     | request instruction at pc from the IFU
// WAIT_INST | waiting for the IFU response, timeout counter running
// ISSUE     | instruction offered to decode/execute
// WAIT_DONE | waiting for EXU completion; commit and redirect here
// HALT      | ebreak or fetch timeout; only reset leaves
module npc_pc_sequencer
  import npc_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR   = 32'h8000_0000,
  parameter int              CNT_W          = 64,
  parameter int unsigned     FETCH_TIMEOUT  = 255,
  parameter int unsigned     ECALL_CAUSE    = ECALL_M,
  parameter int unsigned     MISALIGN_CAUSE = INST_MISALIGNED
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic             idu_valid,
  input  logic             idu_ready,
  output logic [31:0]      idu_inst,
  input  logic             exu_done_valid,
  output logic             exu_done_ready,
  input  logic [XLEN-1:0]  exu_next_pc,
  input  logic             exu_is_ecall,
  input  logic             exu_is_mret,
  input  logic             exu_is_ebreak,
  input  logic [XLEN-1:0]  exu_a0,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic             trap_wen,
  output logic [XLEN-1:0]  trap_mepc,
  output logic [XLEN-1:0]  trap_mcause,
  output logic [XLEN-1:0]  pc,
  output logic             halted,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] retired
);

  state_t          state, state_nx;
  logic [31:0]     to_cnt;
  logic            timeout_hit;
  logic [XLEN-1:0] rd_next_pc, rd_mepc, rd_mcause;
  logic            rd_trap, rd_halt;

  assign timeout_hit = (FETCH_TIMEOUT != 0) && (to_cnt == 32'(FETCH_TIMEOUT))
                       && !ifu_rsp_valid;

  npc_redirect_mux #(
    .XLEN           (XLEN),
    .ECALL_CAUSE    (ECALL_CAUSE),
    .MISALIGN_CAUSE (MISALIGN_CAUSE)
  ) u_redirect (
    .pc          (pc),
    .exu_next_pc (exu_next_pc),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .is_ecall    (exu_is_ecall),
    .is_mret     (exu_is_mret),
    .is_ebreak   (exu_is_ebreak),
    .next_pc     (rd_next_pc),
    .trap        (rd_trap),
    .trap_mepc   (rd_mepc),
    .trap_mcause (rd_mcause),
    .halt        (rd_halt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:     if (ifu_req_ready) state_nx = WAIT_INST;
      WAIT_INST: begin
        if (ifu_rsp_valid)    state_nx = ISSUE;
        else if (timeout_hit) state_nx = HALT;
      end
      ISSUE:     if (idu_ready) state_nx = WAIT_DONE;
      WAIT_DONE: if (exu_done_valid) state_nx = rd_halt ? HALT : FETCH;
      HALT:      state_nx = HALT;
      default:   state_nx = FETCH;
    endcase
  end

  // Valids are held low while reset is asserted, even though state is FETCH.
  always_comb begin
    ifu_req_valid  = 1'b0;
    idu_valid      = 1'b0;
    exu_done_ready = 1'b0;
    if (!rst) begin
      ifu_req_valid  = (state == FETCH);
      idu_valid      = (state == ISSUE);
      exu_done_ready = (state == WAIT_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      idu_inst    <= '0;
      to_cnt      <= '0;
      halted      <= 1'b0;
      exit_code   <= '0;
      retired     <= '0;
      trap_wen    <= 1'b0;
      trap_mepc   <= '0;
      trap_mcause <= '0;
    end else begin
      trap_wen <= 1'b0;
      case (state)
        FETCH: if (ifu_req_ready) to_cnt <= '0;
        WAIT_INST: begin
          to_cnt <= to_cnt + 32'd1;
          if (ifu_rsp_valid) begin
            idu_inst <= ifu_rsp_inst;
          end else if (timeout_hit) begin
            halted    <= 1'b1;
            exit_code <= XLEN'(EXIT_FETCH_TIMEOUT);
          end
        end
        WAIT_DONE: begin
          if (exu_done_valid) begin
            pc          <= rd_next_pc;
            retired     <= retired + CNT_W'(1);
            trap_wen    <= rd_trap;
            trap_mepc   <= rd_mepc;
            trap_mcause <= rd_mcause;
            if (rd_halt) begin
              halted    <= 1'b1;
              exit_code <= exu_a0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
